// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 divider for RV32M div/divu/rem/remu
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  launch request, accepted in IDLE or DONE when kill_i is low
//   op_i     00 div, 01 divu, 10 rem, 11 remu
//   a_i      dividend, sampled on accept
//   b_i      divisor, sampled on accept
//   kill_i   flush; aborts any operation, takes priority over start_i
//   busy_o   high while iterating (state CALC)
//   valid_o  one-cycle pulse with the result on res_o
//   res_o    quotient or remainder, held until the next valid_o
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  kill_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] res_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    logic           rem_sel;   // 1: result is the remainder
    logic           q_neg;
    logic           r_neg;
    logic [W-1:0]   quot;      // holds the dividend, shifted out MSB-first as quotient bits enter
    logic [W-1:0]   divisor;
    logic [W:0]     rem;
    logic [CW-1:0]  count;

    // Operand preparation
    logic           is_signed;
    logic           a_neg;
    logic           b_neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic           div_zero;
    logic           overflow;
    logic [W-1:0]   special_res;

    always_comb begin
        is_signed   = ~op_i[0];
        a_neg       = is_signed & a_i[W-1];
        b_neg       = is_signed & b_i[W-1];
        // |0x80000000| wraps to 0x80000000, which is exactly 2^31 read as unsigned
        a_mag       = a_neg ? (-a_i) : a_i;
        b_mag       = b_neg ? (-b_i) : b_i;
        div_zero    = (b_i == '0);
        overflow    = is_signed & (a_i == MIN_NEG) & (&b_i);
        if (div_zero) begin
            special_res = op_i[1] ? a_i : '1;
        end else begin
            special_res = op_i[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring-division step
    logic [W:0]     rem_shift;
    logic [W+1:0]   diff;
    logic           take;
    logic [W:0]     rem_next;
    logic [W-1:0]   quot_next;
    logic [W-1:0]   mag_res;
    logic [W-1:0]   fin_res;

    always_comb begin
        rem_shift = {rem[W-1:0], quot[W-1]};
        // rem[W] is always zero between steps; it acts as the guard bit of the trial subtract
        diff      = {rem[W], rem_shift} - {2'b00, divisor};
        take      = ~diff[W+1];
        rem_next  = take ? diff[W:0] : rem_shift;
        quot_next = {quot[W-2:0], take};
        // Final result is formed from the last step's outputs so it lands with the DONE transition
        mag_res   = rem_sel ? rem_next[W-1:0] : quot_next;
        fin_res   = (rem_sel ? r_neg : q_neg) ? (-mag_res) : mag_res;
    end

    assign busy_o = (state == CALC);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            rem_sel <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            quot    <= '0;
            divisor <= '0;
            rem     <= '0;
            count   <= '0;
            valid_o <= 1'b0;
            res_o   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (kill_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_i) begin
                            rem_sel <= op_i[1];
                            q_neg   <= (op_i == 2'b00) & (a_i[W-1] ^ b_i[W-1]);
                            r_neg   <= (op_i == 2'b10) & a_i[W-1];
                            count   <= CW'(W);
                            if (div_zero || overflow) begin
                                res_o   <= special_res;
                                valid_o <= 1'b1;
                                state   <= DONE;
                            end else begin
                                quot    <= a_mag;
                                divisor <= b_mag;
                                rem     <= '0;
                                state   <= CALC;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        quot  <= quot_next;
                        rem   <= rem_next;
                        count <= count - 1'b1;
                        if (count == CW'(1)) begin
                            res_o   <= fin_res;
                            valid_o <= 1'b1;
                            state   <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit
module tb_div_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        busy;
    logic        valid;
    logic [31:0] res;

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .kill_i  (kill),
        .busy_o  (busy),
        .valid_o (valid),
        .res_o   (res)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return $signed(x) / $signed(y);
            2'b01:   return x / y;
            2'b10:   return $signed(x) % $signed(y);
            default: return x % y;
        endcase
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_res"}, res, e.res);
                check({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    // Caller is at a negedge; the start is accepted on the following posedge
    task automatic launch(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] want, input int lat);
        exp_t e;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        e.res = want;
        e.lat = lat;
        e.acc = cyc + 1;
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] want, input int lat);
        launch(tag, o, x, y, want, lat);
        drain(tag);
    endtask

    initial begin
        int acc;
        logic [31:0] held;
        logic [31:0] rx;
        logic [31:0] ry;
        logic [1:0]  ro;
        rst_n = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 32);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32);
        run("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32);
        run("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 32);

        launch("divu_5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
        check("divu_5_0_busy", 32'(busy), 32'd0);
        drain("divu_5_0");
        launch("rem_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 0);
        check("rem_5_0_busy", 32'(busy), 32'd0);
        drain("rem_5_0");
        run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);

        for (int i = 0; i < 8; i++) begin
            rx = $urandom;
            ry = $urandom >> $urandom_range(0, 31);
            if (ry == 0) ry = 32'd3;
            ro = 2'(i % 4);
            run($sformatf("rand%0d", i), ro, rx, ry, model(ro, rx, ry), 32);
        end

        // kill in cycle 10 of a divu: the aborted op must never report
        held = res;
        start = 1'b1; op = 2'b01; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        check("kill_busy_before", 32'(busy), 32'd1);
        while (cyc < acc + 9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy_after", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        check("kill_res_held", res, held);
        run("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 32);

        // kill and start together in IDLE launch nothing
        start = 1'b1; kill = 1'b1; op = 2'b01; a = 32'd8; b = 32'd0;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);

        // back-to-back: second start lands in the first op's DONE cycle
        launch("b2b_first", 2'b01, 32'd100, 32'd7, 32'd14, 32);
        acc = cyc;
        while (cyc < acc + 32) @(negedge clk);
        launch("b2b_second", 2'b01, 32'd20, 32'd4, 32'd5, 32);
        drain("b2b");

        // reset asserted in cycle 15 of an operation
        launch("rst_op", 2'b01, 32'd50, 32'd5, 32'd10, 32);
        acc = cyc - 1;
        while (cyc < acc + 14) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run("after_rst", 2'b11, 32'd50, 32'd7, 32'd1, 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
